// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS-subset ID/EX stage.
// Holds ALU control encodings, opcode/funct values and operand forwarding.
package mips_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_XOR = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_SLT = 6'b101010;

    // Register 0 is hard-wired to zero; the younger EX/MEM result beats MEM/WB.
    function automatic logic [31:0] resolve_operand(
        input logic [4:0]  addr,
        input logic [31:0] rf_data,
        input logic        exm_en,
        input logic [4:0]  exm_addr,
        input logic [31:0] exm_data,
        input logic        mwb_en,
        input logic [4:0]  mwb_addr,
        input logic [31:0] mwb_data
    );
        logic [31:0] val;
        if (addr == 5'd0)
            val = 32'd0;
        else if (exm_en && (exm_addr == addr))
            val = exm_data;
        else if (mwb_en && (mwb_addr == addr))
            val = mwb_data;
        else
            val = rf_data;
        return val;
    endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decode: opcode/funct/imm16 to ALU control,
// extended immediate, operand usage, destination select and illegal flag.
module id_decode
    import mips_pkg::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [5:0]  i_funct,
    input  logic [15:0] i_imm16,
    output logic [1:0]  o_alu_ctrl,
    output logic [31:0] o_imm_ext,
    output logic        o_use_imm,
    output logic        o_use_rt,
    output logic        o_dst_rt,
    output logic        o_illegal
);

    logic [31:0] w_sext;
    logic [31:0] w_zext;

    assign w_sext = {{16{i_imm16[15]}}, i_imm16};
    assign w_zext = {16'd0, i_imm16};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        o_alu_ctrl = ALU_ADD;
        o_imm_ext  = 32'd0;
        o_use_imm  = 1'b0;
        o_use_rt   = 1'b0;
        o_dst_rt   = 1'b0;
        o_illegal  = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_use_rt = 1'b1;
                case (i_funct)
                    F_ADD:   o_alu_ctrl = ALU_ADD;
                    F_XOR:   o_alu_ctrl = ALU_XOR;
                    F_SUB:   o_alu_ctrl = ALU_SUB;
                    F_SLT:   o_alu_ctrl = ALU_SLT;
                    default: begin
                        o_use_rt  = 1'b0;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                o_alu_ctrl = ALU_ADD;
                o_imm_ext  = w_sext;
                o_use_imm  = 1'b1;
                o_dst_rt   = 1'b1;
            end
            OP_XORI: begin
                o_alu_ctrl = ALU_XOR;
                o_imm_ext  = w_zext;
                o_use_imm  = 1'b1;
                o_dst_rt   = 1'b1;
            end
            OP_SLTI: begin
                o_alu_ctrl = ALU_SLT;
                o_imm_ext  = w_sext;
                o_use_imm  = 1'b1;
                o_dst_rt   = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes, forwards operands, detects load-use
// hazards and holds ALU inputs behind a valid/ready handshake.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [15:0] imm16,
    input  logic        exm_wr_en,
    input  logic        exm_load,
    input  logic [4:0]  exm_wr_addr,
    input  logic [31:0] exm_wr_data,
    input  logic        mwb_wr_en,
    input  logic [4:0]  mwb_wr_addr,
    input  logic [31:0] mwb_wr_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [1:0]  alu_ctrl,
    output logic [4:0]  dst_addr,
    output logic        dst_wr_en,
    output logic        illegal
);

    logic [1:0]  w_alu_ctrl;
    logic [31:0] w_imm_ext;
    logic        w_use_imm;
    logic        w_use_rt;
    logic        w_dst_rt;
    logic        w_illegal;

    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [4:0]  w_dst;
    logic        w_wr_en;
    logic        w_hazard;
    logic        w_capture;
    logic        w_retire;

    logic        r_out_valid;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [1:0]  r_alu_ctrl;
    logic [4:0]  r_dst_addr;
    logic        r_dst_wr_en;
    logic        r_illegal;

    id_decode u_decode (
        .i_opcode   (opcode),
        .i_funct    (funct),
        .i_imm16    (imm16),
        .o_alu_ctrl (w_alu_ctrl),
        .o_imm_ext  (w_imm_ext),
        .o_use_imm  (w_use_imm),
        .o_use_rt   (w_use_rt),
        .o_dst_rt   (w_dst_rt),
        .o_illegal  (w_illegal)
    );

    assign w_rs_val = resolve_operand(rs_addr, rs_data, exm_wr_en, exm_wr_addr, exm_wr_data,
                                      mwb_wr_en, mwb_wr_addr, mwb_wr_data);
    assign w_rt_val = resolve_operand(rt_addr, rt_data, exm_wr_en, exm_wr_addr, exm_wr_data,
                                      mwb_wr_en, mwb_wr_addr, mwb_wr_data);

    // A load in EX/MEM has no data yet, so a consumer of its target must wait a cycle.
    assign w_hazard = exm_load && exm_wr_en && (exm_wr_addr != 5'd0) && !w_illegal &&
                      ((exm_wr_addr == rs_addr) || (w_use_rt && (exm_wr_addr == rt_addr)));

    assign w_a     = w_illegal ? 32'd0 : w_rs_val;
    assign w_b     = w_illegal ? 32'd0 : (w_use_imm ? w_imm_ext : w_rt_val);
    assign w_dst   = w_illegal ? 5'd0 : (w_dst_rt ? rt_addr : rd_addr);
    assign w_wr_en = !w_illegal && (w_dst != 5'd0);

    assign in_ready  = (!r_out_valid || out_ready) && !w_hazard && !flush;
    assign w_capture = in_valid && in_ready;
    assign w_retire  = r_out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_alu_a     <= 32'd0;
            r_alu_b     <= 32'd0;
            r_alu_ctrl  <= ALU_ADD;
            r_dst_addr  <= 5'd0;
            r_dst_wr_en <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            if (flush)
                r_out_valid <= 1'b0;
            else if (w_capture)
                r_out_valid <= 1'b1;
            else if (w_retire)
                r_out_valid <= 1'b0;

            if (w_capture) begin
                r_alu_a     <= w_a;
                r_alu_b     <= w_b;
                r_alu_ctrl  <= w_alu_ctrl;
                r_dst_addr  <= w_dst;
                r_dst_wr_en <= w_wr_en;
                r_illegal   <= w_illegal;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_ctrl  = r_alu_ctrl;
    assign dst_addr  = r_dst_addr;
    assign dst_wr_en = r_dst_wr_en;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: decode, forwarding,
// load-use stall, backpressure, flush and asynchronous reset.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm16;
    logic        exm_wr_en;
    logic        exm_load;
    logic [4:0]  exm_wr_addr;
    logic [31:0] exm_wr_data;
    logic        mwb_wr_en;
    logic [4:0]  mwb_wr_addr;
    logic [31:0] mwb_wr_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_ctrl;
    logic [4:0]  dst_addr;
    logic        dst_wr_en;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    id_ex_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .funct       (funct),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rd_addr     (rd_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .imm16       (imm16),
        .exm_wr_en   (exm_wr_en),
        .exm_load    (exm_load),
        .exm_wr_addr (exm_wr_addr),
        .exm_wr_data (exm_wr_data),
        .mwb_wr_en   (mwb_wr_en),
        .mwb_wr_addr (mwb_wr_addr),
        .mwb_wr_data (mwb_wr_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .dst_addr    (dst_addr),
        .dst_wr_en   (dst_wr_en),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                             input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsd,
                             input logic [31:0] rtd, input logic [15:0] imm);
        opcode  = op;
        funct   = fn;
        rs_addr = rs;
        rt_addr = rt;
        rd_addr = rd;
        rs_data = rsd;
        rt_data = rtd;
        imm16   = imm;
    endtask

    task automatic clear_fwd();
        exm_wr_en   = 1'b0;
        exm_load    = 1'b0;
        exm_wr_addr = 5'd0;
        exm_wr_data = 32'd0;
        mwb_wr_en   = 1'b0;
        mwb_wr_addr = 5'd0;
        mwb_wr_data = 32'd0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_a"},     alu_a, 0);
        check({tag, "_b"},     alu_b, 0);
        check({tag, "_ctrl"},  alu_ctrl, 0);
        check({tag, "_dst"},   dst_addr, 0);
        check({tag, "_wren"},  dst_wr_en, 0);
        check({tag, "_ill"},   illegal, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        set_instr(6'h00, 6'h20, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0);
        clear_fwd();
        #12 rst_n = 1'b1;
        #1;
        check_reset_values("reset");
        check("reset_in_ready", in_ready, 1);

        // R-type add, no forwarding
        set_instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 16'h0000);
        in_valid = 1'b1;
        check("radd_in_ready", in_ready, 1);
        tick();
        check("radd_valid", out_valid, 1);
        check("radd_a", alu_a, 32'd5);
        check("radd_b", alu_b, 32'd7);
        check("radd_ctrl", alu_ctrl, 2'b00);
        check("radd_dst", dst_addr, 5'd5);
        check("radd_wren", dst_wr_en, 1);
        check("radd_ill", illegal, 0);

        // addi sign-extends, xori zero-extends, back to back
        set_instr(6'h08, 6'h00, 5'd1, 5'd6, 5'd0, 32'd5, 32'd0, 16'hFFFF);
        tick();
        check("addi_valid", out_valid, 1);
        check("addi_b", alu_b, 32'hFFFF_FFFF);
        check("addi_ctrl", alu_ctrl, 2'b00);
        check("addi_dst", dst_addr, 5'd6);
        set_instr(6'h0E, 6'h00, 5'd1, 5'd6, 5'd0, 32'd5, 32'd0, 16'hFFFF);
        tick();
        check("xori_b", alu_b, 32'h0000_FFFF);
        check("xori_ctrl", alu_ctrl, 2'b01);
        set_instr(6'h0A, 6'h00, 5'd1, 5'd6, 5'd0, 32'd5, 32'd0, 16'h8000);
        tick();
        check("slti_b", alu_b, 32'hFFFF_8000);
        check("slti_ctrl", alu_ctrl, 2'b11);

        // Forwarding priority: EX/MEM over MEM/WB over register file
        set_instr(6'h00, 6'h22, 5'd3, 5'd7, 5'd10, 32'hC, 32'd1, 16'h0000);
        exm_wr_en = 1'b1; exm_wr_addr = 5'd3; exm_wr_data = 32'hA;
        mwb_wr_en = 1'b1; mwb_wr_addr = 5'd3; mwb_wr_data = 32'hB;
        tick();
        check("fwd_exm_a", alu_a, 32'hA);
        check("fwd_exm_b", alu_b, 32'd1);
        check("fwd_sub_ctrl", alu_ctrl, 2'b10);
        set_instr(6'h00, 6'h2A, 5'd0, 5'd9, 5'd11, 32'hC, 32'd2, 16'h0000);
        exm_wr_addr = 5'd0; mwb_wr_addr = 5'd9; mwb_wr_data = 32'h55;
        tick();
        check("fwd_r0_a", alu_a, 32'd0);
        check("fwd_mwb_b", alu_b, 32'h55);
        check("fwd_slt_ctrl", alu_ctrl, 2'b11);

        // Drain, then load-use hazard on rt
        in_valid = 1'b0;
        clear_fwd();
        tick();
        check("drain_valid", out_valid, 0);
        exm_load = 1'b1; exm_wr_en = 1'b1; exm_wr_addr = 5'd4; exm_wr_data = 32'hDEAD;
        set_instr(6'h08, 6'h00, 5'd1, 5'd4, 5'd0, 32'd1, 32'd0, 16'h0001);
        #1 check("lu_itype_rt_no_hazard", in_ready, 1);
        set_instr(6'h00, 6'h20, 5'd1, 5'd4, 5'd8, 32'd1, 32'h10, 16'h0000);
        in_valid = 1'b1;
        #1 check("lu_in_ready", in_ready, 0);
        tick();
        check("lu_no_capture", out_valid, 0);
        exm_load = 1'b0; exm_wr_en = 1'b0;
        mwb_wr_en = 1'b1; mwb_wr_addr = 5'd4; mwb_wr_data = 32'h99;
        #1 check("lu_release_ready", in_ready, 1);
        tick();
        check("lu_valid", out_valid, 1);
        check("lu_b", alu_b, 32'h99);
        check("lu_dst", dst_addr, 5'd8);

        // Backpressure for 3 cycles with a pending instruction
        out_ready = 1'b0;
        set_instr(6'h00, 6'h26, 5'd2, 5'd5, 5'd9, 32'h3, 32'h6, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            mwb_wr_data = 32'h1234 + i;
            #1 check("bp_in_ready", in_ready, 0);
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_b_stable", alu_b, 32'h99);
            check("bp_a_stable", alu_a, 32'd1);
            check("bp_dst_stable", dst_addr, 5'd8);
        end
        clear_fwd();
        out_ready = 1'b1;
        #1 check("bp_release_ready", in_ready, 1);
        tick();
        check("b2b_valid", out_valid, 1);
        check("b2b_a", alu_a, 32'h3);
        check("b2b_b", alu_b, 32'h6);
        check("b2b_ctrl", alu_ctrl, 2'b01);
        check("b2b_dst", dst_addr, 5'd9);

        // Flush with a held entry and a new instruction offered
        out_ready = 1'b0;
        set_instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd12, 32'd8, 32'd9, 16'h0000);
        flush = 1'b1;
        #1 check("flush_in_ready", in_ready, 0);
        tick();
        check("flush_valid", out_valid, 0);
        flush = 1'b0;
        out_ready = 1'b1;

        // Asynchronous reset during a hold
        set_instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 16'h0000);
        tick();
        check("pre_rst_valid", out_valid, 1);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_valid", out_valid, 0);

        // Illegal opcode, illegal funct, destination register 0
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_instr(6'h3F, 6'h20, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 16'h1234);
        tick();
        check("ill_op_valid", out_valid, 1);
        check("ill_op_flag", illegal, 1);
        check("ill_op_wren", dst_wr_en, 0);
        check("ill_op_a", alu_a, 32'd0);
        check("ill_op_b", alu_b, 32'd0);
        check("ill_op_ctrl", alu_ctrl, 2'b00);
        set_instr(6'h00, 6'h21, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 16'h0000);
        tick();
        check("ill_fn_flag", illegal, 1);
        check("ill_fn_wren", dst_wr_en, 0);
        set_instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 32'd5, 32'd7, 16'h0000);
        tick();
        check("r0dst_ill", illegal, 0);
        check("r0dst_wren", dst_wr_en, 0);
        check("r0dst_a", alu_a, 32'd5);
        in_valid = 1'b0;
        tick();
        check("final_drain", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
